// File: rtl/uart_tx_gen.sv
// Parametrised UART transmitter: small TX FIFO behind a valid/ready handshake,
// LSB-first serialiser with elaboration-time frame format and a clk_sys bit divider.
module uart_tx_gen #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                  clk_sys,
  input  logic                                  rst_n,
  input  logic [DATA_BITS-1:0]                  tx_data,
  input  logic                                  tx_vld,
  output logic                                  tx_rdy,
  output logic                                  uart_tx,
  output logic                                  busy,
  output logic                                  frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_cnt
);

  localparam int TW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(CLK_DIV - 1);
  localparam logic [IW-1:0] I_LAST   = IW'(DATA_BITS - 1);
  localparam logic          S_LAST   = 1'(STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_gen: CLK_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_gen: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_gen: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_gen: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_gen: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state;
  logic [TW-1:0]         timer;
  logic [IW-1:0]         bit_idx;
  logic                  stop_idx;
  logic [DATA_BITS-1:0]  shreg;
  logic                  par_bit;

  logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_BITS-1:0]  head;
  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  stop_end;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 2) ? ^d : ~^d;
  endfunction

  assign tx_rdy   = (fifo_cnt != CNT_FULL);
  assign push     = tx_vld && tx_rdy;
  assign bit_end  = (timer == T_LAST);
  assign stop_end = (state == S_STOP) && bit_end && (stop_idx == S_LAST);
  // The next word leaves the FIFO either from IDLE or on the very edge the last stop bit ends.
  assign pop      = (fifo_cnt != '0) && ((state == S_IDLE) || stop_end);
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      timer      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      uart_tx    <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != S_IDLE) timer <= bit_end ? '0 : timer + 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg   <= head;
            par_bit <= parity_of(head);
            uart_tx <= 1'b0;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            uart_tx <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx == I_LAST) begin
              if (PARITY != 0) begin
                uart_tx <= par_bit;
                state   <= S_PARITY;
              end else begin
                uart_tx  <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              uart_tx <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            uart_tx  <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx == S_LAST) begin
              frame_done <= 1'b1;
              if (pop) begin
                shreg   <= head;
                par_bit <= parity_of(head);
                uart_tx <= 1'b0;
                state   <= S_START;
              end else begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_gen.sv
// Self-checking bench for uart_tx_gen: four instances (8N1, 8E1, 8O1, 7N2) at CLK_DIV=4,
// a line monitor that slices frames per bit, and a frame model built from the frame rules.
module tb_uart_tx_gen;

  localparam int DIV = 4;

  typedef struct {int idx; logic [15:0] bits; bit glitch; int start;} rx_t;
  typedef struct {int idx; int cyc;} fd_t;

  logic            clk_sys = 1'b0;
  logic            rst_n;
  logic [3:0]      tx_vld, tx_rdy, uart_tx, busy, frame_done;
  logic [3:0][7:0] tx_data;
  logic [3:0][2:0] fifo_cnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  rx_t  rx_q[$];
  fd_t  fd_q[$];

  int          pos[4];
  logic [15:0] cur[4];
  bit          gl[4];
  int          st[4];
  rx_t         rx_tmp;
  fd_t         fd_tmp;

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  uart_tx_gen #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_vld(tx_vld[0]), .tx_rdy(tx_rdy[0]),
    .uart_tx(uart_tx[0]), .busy(busy[0]), .frame_done(frame_done[0]), .fifo_cnt(fifo_cnt[0]));
  uart_tx_gen #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_vld(tx_vld[1]), .tx_rdy(tx_rdy[1]),
    .uart_tx(uart_tx[1]), .busy(busy[1]), .frame_done(frame_done[1]), .fifo_cnt(fifo_cnt[1]));
  uart_tx_gen #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_vld(tx_vld[2]), .tx_rdy(tx_rdy[2]),
    .uart_tx(uart_tx[2]), .busy(busy[2]), .frame_done(frame_done[2]), .fifo_cnt(fifo_cnt[2]));
  uart_tx_gen #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut3 (
    .clk_sys(clk_sys), .rst_n(rst_n), .tx_data(tx_data[3][6:0]), .tx_vld(tx_vld[3]), .tx_rdy(tx_rdy[3]),
    .uart_tx(uart_tx[3]), .busy(busy[3]), .frame_done(frame_done[3]), .fifo_cnt(fifo_cnt[3]));

  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : (i == 2) ? 1 : 0;
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int model_len(input int i);
    return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction

  // Line bits in transmission order: bit 0 of the result is the start bit.
  function automatic logic [15:0] model_frame(input int i, input logic [7:0] w);
    logic [15:0] f;
    int n;
    int ones;
    f = '0;
    n = 1;
    ones = 0;
    for (int k = 0; k < db_of(i); k++) begin
      f[n] = w[k];
      ones += int'(w[k]);
      n++;
    end
    if (par_of(i) == 2) begin f[n] = (ones % 2 == 1); n++; end
    if (par_of(i) == 1) begin f[n] = (ones % 2 == 0); n++; end
    for (int k = 0; k < sb_of(i); k++) begin f[n] = 1'b1; n++; end
    return f;
  endfunction

  // Slices each frame into DIV-cycle bits and flags any bit that is not held for all DIV samples.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pos[i] = -1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (frame_done[i] === 1'b1) begin
          fd_tmp.idx = i;
          fd_tmp.cyc = cyc;
          fd_q.push_back(fd_tmp);
        end
        if (pos[i] < 0 && uart_tx[i] === 1'b0) begin
          pos[i] = 0; cur[i] = '0; gl[i] = 1'b0; st[i] = cyc;
        end
        if (pos[i] >= 0) begin
          if (pos[i] % DIV == 0) cur[i][pos[i] / DIV] = uart_tx[i];
          else if (uart_tx[i] !== cur[i][pos[i] / DIV]) gl[i] = 1'b1;
          pos[i]++;
          if (pos[i] == model_len(i) * DIV) begin
            rx_tmp.idx = i; rx_tmp.bits = cur[i]; rx_tmp.glitch = gl[i]; rx_tmp.start = st[i];
            rx_q.push_back(rx_tmp);
            pos[i] = -1;
          end
        end
      end
    end
  end

  task automatic send_word(input int idx, input logic [7:0] w, output int acc);
    acc = -1;
    tx_data[idx] = w;
    tx_vld[idx] = 1'b1;
    for (int t = 0; t < 400; t++) begin
      if (tx_rdy[idx] === 1'b1) begin
        acc = cyc + 1;
        @(negedge clk_sys);
        break;
      end
      @(negedge clk_sys);
    end
    tx_vld[idx] = 1'b0;
    if (acc < 0) begin
      checks++; errors++;
      $display("[TB] FAIL send_word dut%0d tx_rdy never high, word %h not accepted", idx, w);
    end
  endtask

  task automatic wait_frames(input int n, input int budget);
    for (int t = 0; t < budget && rx_q.size() < n; t++) @(negedge clk_sys);
    if (rx_q.size() < n) begin
      checks++; errors++;
      $display("[TB] FAIL wait_frames got %0d frames, required %0d", rx_q.size(), n);
    end
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      checks++; if (uart_tx[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset_uart_tx dut%0d got %b want 1", i, uart_tx[i]); end
      checks++; if (busy[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy dut%0d got %b want 0", i, busy[i]); end
      checks++; if (frame_done[i] !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done dut%0d got %b want 0", i, frame_done[i]); end
      checks++; if (fifo_cnt[i] !== 3'd0) begin errors++; $display("[TB] FAIL reset_fifo_cnt dut%0d got %0d want 0", i, fifo_cnt[i]); end
      checks++; if (tx_rdy[i] !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx_rdy dut%0d got %b want 1", i, tx_rdy[i]); end
    end
  endtask

  task automatic test_frame_8n1();
    int acc;
    rx_t r;
    rx_q.delete(); fd_q.delete();
    send_word(0, 8'hA5, acc);
    checks++; if (fifo_cnt[0] !== 3'd1 || busy[0] !== 1'b0 || uart_tx[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL latency_accept cnt/busy/line got %0d/%b/%b want 1/0/1", fifo_cnt[0], busy[0], uart_tx[0]); end
    @(negedge clk_sys);
    checks++; if (fifo_cnt[0] !== 3'd0 || busy[0] !== 1'b1 || uart_tx[0] !== 1'b0) begin
      errors++; $display("[TB] FAIL latency_start cnt/busy/line got %0d/%b/%b want 0/1/0", fifo_cnt[0], busy[0], uart_tx[0]); end
    wait_frames(1, 200);
    if (rx_q.size() >= 1) begin
      r = rx_q.pop_front();
      checks++; if (r.bits[9:0] !== 10'b11_0100_1010) begin errors++; $display("[TB] FAIL a5_line got %b want 1101001010", r.bits[9:0]); end
      checks++; if (r.bits !== model_frame(0, 8'hA5)) begin errors++; $display("[TB] FAIL a5_model got %h want %h", r.bits, model_frame(0, 8'hA5)); end
      checks++; if (r.glitch) begin errors++; $display("[TB] FAIL a5_bit_width got glitch 1 want 0"); end
      checks++; if (r.start != acc + 1) begin errors++; $display("[TB] FAIL a5_start_cycle got %0d want %0d", r.start, acc + 1); end
      checks++; if (fd_q.size() != 1 || fd_q[0].cyc != r.start + 40) begin
        errors++; $display("[TB] FAIL a5_frame_done count %0d cycle %0d want 1 at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0].cyc : -1, r.start + 40); end
    end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL a5_busy_after got %b want 0", busy[0]); end
  endtask

  task automatic test_parity();
    logic [7:0] w [4];
    int acc;
    rx_t r;
    for (int idx = 1; idx <= 2; idx++) begin
      w[0] = 8'hA5; w[1] = 8'h01; w[2] = 8'($urandom_range(0, 255)); w[3] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 4; k++) begin
        rx_q.delete(); fd_q.delete();
        send_word(idx, w[k], acc);
        wait_frames(1, 200);
        if (rx_q.size() >= 1) begin
          r = rx_q.pop_front();
          checks++; if (r.bits !== model_frame(idx, w[k]) || r.glitch) begin
            errors++; $display("[TB] FAIL parity_frame dut%0d word %h got %h glitch %b want %h", idx, w[k], r.bits, r.glitch, model_frame(idx, w[k])); end
          if (k < 2) begin
            checks++; if (r.bits[9] !== ((idx == 1) ? (k == 1) : (k == 0))) begin
              errors++; $display("[TB] FAIL parity_bit dut%0d word %h got %b want %b", idx, w[k], r.bits[9], (idx == 1) ? (k == 1) : (k == 0)); end
          end
          checks++; if (fd_q.size() != 1 || fd_q[0].cyc != r.start + 44) begin
            errors++; $display("[TB] FAIL parity_frame_done dut%0d count %0d want 1 at %0d", idx, fd_q.size(), r.start + 44); end
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] w [6];
    int j;
    bit full_checked;
    rx_t r;
    for (int k = 0; k < 6; k++) w[k] = 8'($urandom_range(0, 255));
    rx_q.delete(); fd_q.delete();
    j = 0; full_checked = 0;
    tx_data[0] = w[0]; tx_vld[0] = 1'b1;
    for (int t = 0; t < 400 && j < 6; t++) begin
      if (j == 5 && !full_checked) begin
        full_checked = 1;
        checks++; if (fifo_cnt[0] !== 3'd4 || tx_rdy[0] !== 1'b0) begin
          errors++; $display("[TB] FAIL fifo_full cnt/rdy got %0d/%b want 4/0", fifo_cnt[0], tx_rdy[0]); end
      end
      if (tx_rdy[0] === 1'b1) begin
        if (j == 5) begin
          checks++; if (frame_done[0] !== 1'b1) begin errors++; $display("[TB] FAIL sixth_accept_timing frame_done got %b want 1", frame_done[0]); end
        end
        j++;
        @(negedge clk_sys);
        if (j < 6) tx_data[0] = w[j];
      end else begin
        @(negedge clk_sys);
      end
    end
    tx_vld[0] = 1'b0;
    checks++; if (j != 6) begin errors++; $display("[TB] FAIL fifo_accepts got %0d want 6", j); end
    wait_frames(6, 400);
    for (int k = 0; k < 6 && rx_q.size() > k; k++) begin
      r = rx_q[k];
      checks++; if (r.bits !== model_frame(0, w[k]) || r.glitch) begin
        errors++; $display("[TB] FAIL fifo_order frame %0d got %h glitch %b want %h", k, r.bits, r.glitch, model_frame(0, w[k])); end
      if (k > 0) begin
        checks++; if (r.start != rx_q[k-1].start + 40) begin
          errors++; $display("[TB] FAIL fifo_gap frame %0d start got %0d want %0d", k, r.start, rx_q[k-1].start + 40); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    rx_q.delete(); fd_q.delete();
    send_word(0, 8'h00, acc);
    send_word(0, 8'hFF, acc);
    wait_frames(2, 200);
    if (rx_q.size() >= 2) begin
      checks++; if (rx_q[0].bits !== model_frame(0, 8'h00) || rx_q[1].bits !== model_frame(0, 8'hFF)) begin
        errors++; $display("[TB] FAIL b2b_frames got %h %h want %h %h", rx_q[0].bits, rx_q[1].bits, model_frame(0, 8'h00), model_frame(0, 8'hFF)); end
      checks++; if (rx_q[1].start != rx_q[0].start + 40) begin
        errors++; $display("[TB] FAIL b2b_start_gap got %0d want 40", rx_q[1].start - rx_q[0].start); end
      checks++; if (fd_q.size() != 2 || fd_q[0].cyc != rx_q[1].start) begin
        errors++; $display("[TB] FAIL b2b_frame_done count %0d first at %0d want 2, first at %0d", fd_q.size(), (fd_q.size() > 0) ? fd_q[0].cyc : -1, rx_q[1].start); end
    end
  endtask

  task automatic test_stop2();
    int acc;
    rx_t r;
    rx_q.delete(); fd_q.delete();
    send_word(3, 8'h7F, acc);
    wait_frames(1, 200);
    if (rx_q.size() >= 1) begin
      r = rx_q.pop_front();
      checks++; if (r.bits[9:0] !== 10'b11_1111_1110 || r.glitch) begin
        errors++; $display("[TB] FAIL stop2_line got %b glitch %b want 1111111110", r.bits[9:0], r.glitch); end
      checks++; if (fd_q.size() != 1 || fd_q[0].cyc != r.start + 40) begin
        errors++; $display("[TB] FAIL stop2_frame_done count %0d want 1 at %0d", fd_q.size(), r.start + 40); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] w1, w2, w3;
    int acc, acc2;
    rx_t r;
    w1 = 8'($urandom_range(0, 255)); w2 = 8'($urandom_range(0, 255)); w3 = 8'($urandom_range(0, 255));
    rx_q.delete(); fd_q.delete();
    send_word(0, w1, acc);
    send_word(0, w2, acc2);
    for (int t = 0; t < 200 && cyc < acc + 18; t++) @(negedge clk_sys);
    checks++; if (uart_tx[0] !== w1[3]) begin errors++; $display("[TB] FAIL midframe_bit3 got %b want %b", uart_tx[0], w1[3]); end
    rst_n = 1'b0;
    #1;
    checks++; if (uart_tx[0] !== 1'b1 || fifo_cnt[0] !== 3'd0 || busy[0] !== 1'b0 || tx_rdy[0] !== 1'b1) begin
      errors++; $display("[TB] FAIL midreset_state line/cnt/busy/rdy got %b/%0d/%b/%b want 1/0/0/1", uart_tx[0], fifo_cnt[0], busy[0], tx_rdy[0]); end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    rx_q.delete(); fd_q.delete();
    @(negedge clk_sys);
    send_word(0, w3, acc);
    wait_frames(1, 200);
    repeat (100) @(negedge clk_sys);
    checks++; if (rx_q.size() != 1) begin errors++; $display("[TB] FAIL post_reset_frames got %0d want 1", rx_q.size()); end
    if (rx_q.size() >= 1) begin
      r = rx_q.pop_front();
      checks++; if (r.bits !== model_frame(0, w3) || r.glitch || r.start != acc + 1) begin
        errors++; $display("[TB] FAIL post_reset_frame got %h glitch %b start %0d want %h start %0d", r.bits, r.glitch, r.start, model_frame(0, w3), acc + 1); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] w;
    int acc;
    for (int idx = 0; idx < 4; idx++) begin
      rx_q.delete(); fd_q.delete(); exp_q.delete();
      for (int k = 0; k < 8; k++) begin
        repeat ($urandom_range(0, 60)) @(negedge clk_sys);
        w = 8'($urandom_range(0, (1 << db_of(idx)) - 1));
        send_word(idx, w, acc);
        if (acc >= 0) exp_q.push_back(w);
      end
      wait_frames(exp_q.size(), 800);
      checks++; if (rx_q.size() != exp_q.size() || fd_q.size() != exp_q.size()) begin
        errors++; $display("[TB] FAIL random_count dut%0d frames %0d done %0d want %0d", idx, rx_q.size(), fd_q.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < rx_q.size(); k++) begin
        checks++; if (rx_q[k].bits !== model_frame(idx, exp_q[k]) || rx_q[k].glitch) begin
          errors++; $display("[TB] FAIL random_frame dut%0d #%0d got %h glitch %b want %h", idx, k, rx_q[k].bits, rx_q[k].glitch, model_frame(idx, exp_q[k])); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    tx_vld = '0;
    tx_data = '0;
    repeat (3) @(negedge clk_sys);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    test_frame_8n1();
    test_parity();
    test_fifo_full();
    test_back_to_back();
    test_stop2();
    test_reset_midframe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
